ft2232h_rx: RTL and testbench
=============================

// Module: ft2232h_rx
// PURPOSE
//  Receive half of the FT2232H 245-style synchronous FIFO link, complementing the transmit block.
//  Drains bytes the host has queued in the FT2232H RX buffer (RXF# low) using the OE#/RD# handshake.
//  Lands captured bytes in an internal FIFO, presented to fabric logic on a valid/ready stream.
//  Sits beside the TX block on comm_clk (the 60 MHz CLKOUT from the FT2232H).
// PARAMETERS
//  DEPTH   16  internal FIFO entries; power of two, >= 4
//  ADDR_W  4   log2(DEPTH); derived, do not override independently
// PORTS
//  clk       in   1  comm_clk from FT2232H CLKOUT; all logic on rising edge
//  reset_n   in   1  asynchronous, active-low reset
//  enable    in   1  1 = reads permitted; 0 = finish current cycle, then idle
//  rxf_n     in   1  FT2232H RXF#; 0 = byte available on data_in
//  data_in   in   8  FT2232H ADBUS, driven by the chip while oe_n = 0
//  oe_n      out  1  FT2232H OE#; 0 = chip drives bus
//  rd_n      out  1  FT2232H RD#; 0 = advance chip FIFO each clk
//  m_data    out  8  received byte, head of internal FIFO
//  m_valid   out  1  m_data holds a valid byte
//  m_ready   in   1  consumer accepts m_data this cycle
//  level     out  ADDR_W+1  current internal FIFO occupancy, 0..DEPTH
//  overflow  out  1  sticky protocol error: capture attempted while FIFO full
// BEHAVIOUR
//  Reset (async assert, sync release): oe_n=1, rd_n=1, m_valid=0, level=0, overflow=0, FSM=IDLE, pointers=0.
//  Reset mid-burst: oe_n and rd_n go high immediately, without waiting for clk; FIFO contents are discarded.
//  All outputs are registered; oe_n and rd_n come straight from flops.
//  free = DEPTH - level.
//  FSM:
//   IDLE: oe_n=1, rd_n=1.
//    -> OE when enable=1, rxf_n=0 and free>=2.
//   OE: oe_n=0, rd_n=1 (bus turnaround; exactly one cycle, no capture).
//    -> READ unconditionally.
//   READ: oe_n=0, rd_n=0.
//    -> IDLE (oe_n=1, rd_n=1 on the following edge) when any of these holds: rxf_n=1,
//       enable=0, or (free - cap) < 1 with pop excluded.
//    Otherwise stay in READ.
//  Capture rule (cap): on an edge where registered rd_n=0 and rxf_n=0, data_in is written to the FIFO.
//   - No capture while rxf_n=1, even with rd_n low.
//   - No capture in IDLE or OE.
//  Headroom: rd_n is registered, so one further capture can occur on the edge after a stop decision.
//   The exit condition above guarantees a free slot for it. Hence overflow must never set in correct
//   operation; if it does, the byte is dropped and overflow stays 1 until reset.
//  Internal FIFO: first-word-fall-through.
//   - m_valid = (level != 0); m_data = entry at the read pointer.
//   - Pop when m_valid & m_ready.
//   - Push and pop on the same edge: level unchanged, both pointers advance. This is legal at full
//     and at empty; at empty the pushed byte appears on the next cycle.
//   - Pointers wrap modulo DEPTH.
//   - m_data and m_valid must not change while m_valid=1 and m_ready=0.
//  Latency: byte captured at edge N -> m_valid=1 with that byte after edge N (next cycle), if FIFO was empty.
//  Ordering: bytes leave in exactly the order they were captured; none duplicated, none skipped.
// TESTING
//  1. rxf_n=0 with 5 bytes 0x10..0x14, m_ready=1, enable=1 -> oe_n low 1 cycle before rd_n;
//     0x10..0x14 out in order; rd_n and oe_n high 1 cycle after rxf_n rises.
//  2. 40 bytes 0x00..0x27 queued, m_ready=0, DEPTH=16 -> rd_n high with level=16 and overflow=0;
//     then m_ready=1 -> burst resumes, all 40 bytes delivered in order.
//  3. rxf_n high for 3 cycles mid-burst (after 0x05) -> no capture in those cycles; FSM to IDLE,
//     re-enters OE->READ; stream continuous 0x00..0x0F.
//  4. enable=0 after 4 bytes -> rd_n high next edge, at most 1 extra byte captured;
//     enable=1 -> resumes with the next byte, no loss.
//  5. reset_n=0 during READ with level=6 -> oe_n=1, rd_n=1, m_valid=0, level=0 asynchronously,
//     before the next clk edge.
//  6. FIFO full, m_ready=1 while capturing -> level holds 16, no overflow, order preserved
//     across pointer wrap.

Source files
------------

// File: rtl/ft2232h_rx.sv
`default_nettype none
// ============================================================================
// Module      : ft2232h_rx
// Description : Receive half of the FT2232H 245-style synchronous FIFO link.
//               Drains the chip RX buffer with the OE#/RD# handshake and lands
//               bytes in an internal first-word-fall-through FIFO, presented
//               on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ft2232h_rx #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rxf_n,
  input  logic [7:0]        data_in,
  output logic              oe_n,
  output logic              rd_n,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              cap;
  logic              pop;
  logic              push;
  logic              full;
  logic [ADDR_W:0]   free;
  logic [ADDR_W+1:0] level_plus_cap;
  logic              no_room;

  // A byte is taken from the bus whenever the registered strobe is low and
  // the chip still reports data; this includes the single trailing capture
  // on the edge that acts on a stop decision.
  assign cap     = ~rd_n & ~rxf_n;
  assign pop     = m_valid & m_ready;
  assign full    = (level == DEPTH_L);
  assign push    = cap & (~full | pop);
  assign free    = DEPTH_L - level;
  assign m_valid = (level != '0);
  assign m_data  = mem[rd_ptr];

  // Stop reading once this edge's capture would leave no slot for the
  // capture that the still-low registered strobe allows on the next edge.
  // Pops are deliberately ignored so the decision never depends on the
  // consumer.
  assign level_plus_cap = {1'b0, level} + {{(ADDR_W + 1){1'b0}}, cap};
  assign no_room        = (level_plus_cap >= {1'b0, DEPTH_L});

  // Next-state logic for the read handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable && !rxf_n && (free >= (ADDR_W + 1)'(2))) begin
          state_nxt = ST_OE;
        end
      end
      ST_OE: begin
        state_nxt = ST_READ;
      end
      ST_READ: begin
        if (rxf_n || !enable || no_room) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; OE#/RD# are flops decoded from the next state so they
  // change on the same edge as the state and release on async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      oe_n  <= 1'b1;
      rd_n  <= 1'b1;
    end else begin
      state <= state_nxt;
      oe_n  <= (state_nxt == ST_IDLE);
      rd_n  <= (state_nxt != ST_READ);
    end
  end

  // FIFO storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
      if (cap && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft2232h_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ft2232h_rx
// Description : Self-checking bench for ft2232h_rx. Models the FT2232H RX
//               buffer as a byte queue and checks the stream against the
//               bytes the chip handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft2232h_rx;

  localparam int DEPTH = 16;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       rxf_n   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       m_ready = 1'b0;
  logic       oe_n;
  logic       rd_n;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] host_q[$];   // bytes still inside the chip
  logic [7:0] exp_q[$];    // bytes handed over but not yet consumed
  int         n_cap = 0;
  int         n_pop = 0;
  int         gap_cnt = 0;
  int         gap_after = -1;
  bit         cap_pending = 1'b0;
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  ft2232h_rx #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .rxf_n    (rxf_n),
    .data_in  (data_in),
    .oe_n     (oe_n),
    .rd_n     (rd_n),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Chip model: a read happens on an edge where RD# and RXF# are both low.
  always @(negedge clk) cap_pending = reset_n && !rd_n && !rxf_n;

  // Chip model: advance its buffer after a read and update RXF#/data.
  always @(posedge clk) begin
    #1;
    if (gap_cnt > 0) gap_cnt--;
    if (cap_pending && reset_n && host_q.size() > 0) begin
      exp_q.push_back(host_q[0]);
      if (int'(host_q[0]) == gap_after) begin
        gap_cnt   = 3;
        gap_after = -1;
      end
      void'(host_q.pop_front());
      n_cap++;
    end
    cap_pending = 1'b0;
    rxf_n   = (host_q.size() == 0) || (gap_cnt > 0);
    data_in = (host_q.size() > 0) ? host_q[0] : 8'h00;
  end

  // Stream monitor: occupancy, ordering, stability and overflow.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      checks++;
      if (level !== 5'(exp_q.size())) begin
        errors++;
        $display("FAIL level: got %0d expected %0d", level, exp_q.size());
      end
      checks++;
      if (m_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL m_valid: got %b expected %b", m_valid, exp_q.size() != 0);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL overflow: got %b expected 0", overflow);
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL order: got %h expected no byte", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL order: got %h expected %h", m_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_pop++;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wait_drain(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_pop >= target && host_q.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_counts();
    @(posedge clk); #2;
    n_cap = 0;
    n_pop = 0;
  endtask

  task automatic test_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b expected 1", oe_n); end
    checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b expected 1", rd_n); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    #1 reset_n = 1'b1;
    prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    bit seen;
    clear_counts();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) host_q.push_back(8'(8'h10 + i));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (oe_n === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_oe_timeout: got oe_n=%b expected 0", oe_n); end
    checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL basic_turnaround: got rd_n=%b expected 1", rd_n); end
    @(negedge clk);
    checks++; if (rd_n !== 1'b0 || oe_n !== 1'b0) begin errors++; $display("FAIL basic_read: got rd_n=%b oe_n=%b expected 0 0", rd_n, oe_n); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rxf_n === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || rd_n !== 1'b0) begin errors++; $display("FAIL basic_rxf_rise: got rd_n=%b expected 0", rd_n); end
    @(negedge clk);
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL basic_stop: got rd_n=%b oe_n=%b expected 1 1", rd_n, oe_n); end
    wait_drain(5, 100, ok);
    checks++; if (!ok || n_pop != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", n_pop); end
  endtask

  task automatic test_back_to_back_full();
    bit ok;
    clear_counts();
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) host_q.push_back(8'(i));
    repeat (40) @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d expected 16", level); end
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL full_stop: got rd_n=%b oe_n=%b expected 1 1", rd_n, oe_n); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    @(posedge clk); #2 m_ready = 1'b1;
    wait_drain(40, 400, ok);
    checks++; if (!ok || n_pop != 40) begin errors++; $display("FAIL full_count: got %0d expected 40", n_pop); end
  endtask

  task automatic test_rxf_gap();
    bit ok;
    bit seen;
    clear_counts();
    enable    = 1'b1;
    m_ready   = 1'b1;
    gap_after = 5;
    for (int i = 0; i < 16; i++) host_q.push_back(8'(i));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (gap_cnt > 0) seen = 1'b1;
    end
    checks++; if (!seen || rxf_n !== 1'b1) begin errors++; $display("FAIL gap_start: got rxf_n=%b expected 1", rxf_n); end
    @(negedge clk);
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL gap_idle: got rd_n=%b oe_n=%b expected 1 1", rd_n, oe_n); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (oe_n === 1'b0) seen = 1'b1;
    end
    checks++; if (!seen || rd_n !== 1'b1) begin errors++; $display("FAIL gap_reenter: got oe_n=%b rd_n=%b expected 0 1", oe_n, rd_n); end
    wait_drain(16, 200, ok);
    checks++; if (!ok || n_pop != 16) begin errors++; $display("FAIL gap_count: got %0d expected 16", n_pop); end
  endtask

  task automatic test_enable();
    bit ok;
    int c0;
    clear_counts();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) host_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 40 && n_cap < 4; i++) begin
      @(posedge clk); #2;
    end
    enable = 1'b0;
    c0 = n_cap;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL enable_stop: got rd_n=%b oe_n=%b expected 1 1", rd_n, oe_n); end
    repeat (4) @(negedge clk);
    checks++; if (n_cap - c0 > 1) begin errors++; $display("FAIL enable_extra: got %0d extra expected <=1", n_cap - c0); end
    checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL enable_idle: got rd_n=%b expected 1", rd_n); end
    @(posedge clk); #2 enable = 1'b1;
    wait_drain(10, 200, ok);
    checks++; if (!ok || n_pop != 10) begin errors++; $display("FAIL enable_count: got %0d expected 10", n_pop); end
  endtask

  task automatic test_reset_midburst();
    bit seen;
    clear_counts();
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) host_q.push_back(8'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (level === 5'd6) seen = 1'b1;
    end
    checks++; if (!seen || rd_n !== 1'b0) begin errors++; $display("FAIL rst_mid_setup: got level=%0d rd_n=%b expected 6 0", level, rd_n); end
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (oe_n !== 1'b1 || rd_n !== 1'b1) begin errors++; $display("FAIL rst_mid_pins: got oe_n=%b rd_n=%b expected 1 1", oe_n, rd_n); end
    checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL rst_mid_fifo: got valid=%b level=%0d expected 0 0", m_valid, level); end
    host_q.delete();
    exp_q.delete();
    gap_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_n    = 1'b1;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (level !== 5'd0 || rd_n !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got level=%0d rd_n=%b expected 0 1", level, rd_n); end
  endtask

  task automatic test_random_wrap();
    bit ok;
    clear_counts();
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 80; i++) host_q.push_back(8'($urandom));
    repeat (30) @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL wrap_fill: got %0d expected 16", level); end
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #2;
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      if (n_pop >= 80 && host_q.size() == 0 && exp_q.size() == 0) ok = 1'b1;
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    checks++; if (!ok || n_pop != 80) begin errors++; $display("FAIL wrap_count: got %0d expected 80", n_pop); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_full();
    test_rxf_gap();
    test_enable();
    test_reset_midburst();
    test_random_wrap();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
